// File: rtl/mem_stage_pkg.sv
// ---------------------------------------------------------------------------
// mem_stage_pkg
// Shared sizes, FSM state encoding and small helpers for the memory stage.
//   REG_SIZE  : register / data width
//   ADDR_SIZE : data-memory address width
//   REG_ADDR  : register-file index width
// ---------------------------------------------------------------------------
package mem_stage_pkg;

    localparam int REG_SIZE  = 32;
    localparam int ADDR_SIZE = 32;
    localparam int REG_ADDR  = 5;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } state_e;

    // Memory is word addressed on the bus: the byte offset never leaves the stage.
    function automatic logic [ADDR_SIZE-1:0] word_addr(input logic [REG_SIZE-1:0] a);
        return {a[ADDR_SIZE-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/mem_stage_if.sv
// ---------------------------------------------------------------------------
// mem_stage_if
// Bundle of all non-clock/reset signals of the memory stage.
//   execute side : valid_in, alu_result, data_store, do_read, do_write,
//                  is_byte, memtoreg, regwrite_in, dst_reg_in, stall
//   memory side  : mem_req, mem_we, mem_addr, mem_wdata, mem_be,
//                  mem_ack, mem_rdata
//   write-back   : wb_valid, wb_regwrite, wb_data, wb_dst_reg
// slave  = view of the memory stage itself
// master = view of the surrounding pipeline / memory / bench
// ---------------------------------------------------------------------------
interface mem_stage_if;
    import mem_stage_pkg::*;

    logic                  valid_in;
    logic [REG_SIZE-1:0]   alu_result;
    logic [REG_SIZE-1:0]   data_store;
    logic                  do_read;
    logic                  do_write;
    logic                  is_byte;
    logic                  memtoreg;
    logic                  regwrite_in;
    logic [REG_ADDR-1:0]   dst_reg_in;

    logic                  mem_req;
    logic                  mem_we;
    logic [ADDR_SIZE-1:0]  mem_addr;
    logic [REG_SIZE-1:0]   mem_wdata;
    logic [3:0]            mem_be;
    logic                  mem_ack;
    logic [REG_SIZE-1:0]   mem_rdata;

    logic                  stall;
    logic                  wb_valid;
    logic                  wb_regwrite;
    logic [REG_SIZE-1:0]   wb_data;
    logic [REG_ADDR-1:0]   wb_dst_reg;

    modport slave (
        input  valid_in, alu_result, data_store, do_read, do_write,
               is_byte, memtoreg, regwrite_in, dst_reg_in,
               mem_ack, mem_rdata,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
               stall, wb_valid, wb_regwrite, wb_data, wb_dst_reg
    );

    modport master (
        output valid_in, alu_result, data_store, do_read, do_write,
               is_byte, memtoreg, regwrite_in, dst_reg_in,
               mem_ack, mem_rdata,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
               stall, wb_valid, wb_regwrite, wb_data, wb_dst_reg
    );

endinterface

// File: rtl/mem_stage_align.sv
// ---------------------------------------------------------------------------
// mem_align (combinational)
// Byte-lane handling for the memory stage.
//   i_is_byte    : byte access (else word)
//   i_lane       : byte offset within the word (lane 0 = bits 7:0)
//   i_store_data : register value to store
//   i_load_data  : raw word returned by memory
//   o_be         : byte enables (one-hot for byte, all ones for word)
//   o_wdata      : store data, low byte replicated on every lane for bytes
//   o_load_data  : word as-is, or selected lane sign-extended for bytes
// ---------------------------------------------------------------------------
module mem_align
    import mem_stage_pkg::*;
(
    input  logic                i_is_byte,
    input  logic [1:0]          i_lane,
    input  logic [REG_SIZE-1:0] i_store_data,
    input  logic [REG_SIZE-1:0] i_load_data,
    output logic [3:0]          o_be,
    output logic [REG_SIZE-1:0] o_wdata,
    output logic [REG_SIZE-1:0] o_load_data
);

    logic [7:0]          w_lane_bytes [4];
    logic [3:0]          w_onehot;
    logic [REG_SIZE-1:0] w_repl;
    logic [7:0]          w_sel;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign w_lane_bytes[gi]     = i_load_data[8*gi +: 8];
            assign w_onehot[gi]         = (i_lane == 2'(gi));
            assign w_repl[8*gi +: 8]    = i_store_data[7:0];
        end
    endgenerate

    assign w_sel       = w_lane_bytes[i_lane];
    assign o_be        = i_is_byte ? w_onehot : 4'b1111;
    assign o_wdata     = i_is_byte ? w_repl : i_store_data;
    assign o_load_data = i_is_byte ? {{(REG_SIZE-8){w_sel[7]}}, w_sel} : i_load_data;

endmodule

// File: rtl/mem_stage.sv
// ---------------------------------------------------------------------------
// mem_stage
// Memory pipeline stage: ALU results pass straight to write-back in one
// cycle; loads/stores issue a single held request to data memory and retire
// the cycle after mem_ack. One operation in flight; stall holds upstream.
//   clk   : clock, rising edge
//   reset : asynchronous, active-low
//   bus   : mem_stage_if.slave (execute bundle, memory port, write-back)
// ---------------------------------------------------------------------------
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    mem_stage_if.slave   bus
);

    state_e                r_state, w_state_next;

    logic                  r_mem_req,   w_mem_req_next;
    logic                  r_mem_we,    w_mem_we_next;
    logic [ADDR_SIZE-1:0]  r_mem_addr,  w_mem_addr_next;
    logic [REG_SIZE-1:0]   r_mem_wdata, w_mem_wdata_next;
    logic [3:0]            r_mem_be,    w_mem_be_next;

    // Captured bundle, needed when the memory answers.
    logic [1:0]            r_lane,      w_lane_next;
    logic                  r_is_byte,   w_is_byte_next;
    logic                  r_memtoreg,  w_memtoreg_next;
    logic                  r_regwrite,  w_regwrite_next;
    logic [REG_ADDR-1:0]   r_dst,       w_dst_next;
    logic [REG_SIZE-1:0]   r_alu,       w_alu_next;

    logic                  r_wb_valid,    w_wb_valid_next;
    logic                  r_wb_regwrite, w_wb_regwrite_next;
    logic [REG_SIZE-1:0]   r_wb_data,     w_wb_data_next;
    logic [REG_ADDR-1:0]   r_wb_dst,      w_wb_dst_next;

    logic [1:0]            w_align_lane;
    logic                  w_align_byte;
    logic [3:0]            w_be;
    logic [REG_SIZE-1:0]   w_wdata;
    logic [REG_SIZE-1:0]   w_load_data;

    // One aligner serves both directions: in IDLE it shapes the incoming
    // store, in REQ it extracts the lane of the captured load.
    assign w_align_lane = (r_state == ST_REQ) ? r_lane    : bus.alu_result[1:0];
    assign w_align_byte = (r_state == ST_REQ) ? r_is_byte : bus.is_byte;

    mem_align u_align (
        .i_is_byte    (w_align_byte),
        .i_lane       (w_align_lane),
        .i_store_data (bus.data_store),
        .i_load_data  (bus.mem_rdata),
        .o_be         (w_be),
        .o_wdata      (w_wdata),
        .o_load_data  (w_load_data)
    );

    always_comb begin
        w_state_next       = r_state;
        w_mem_req_next     = r_mem_req;
        w_mem_we_next      = r_mem_we;
        w_mem_addr_next    = r_mem_addr;
        w_mem_wdata_next   = r_mem_wdata;
        w_mem_be_next      = r_mem_be;
        w_lane_next        = r_lane;
        w_is_byte_next     = r_is_byte;
        w_memtoreg_next    = r_memtoreg;
        w_regwrite_next    = r_regwrite;
        w_dst_next         = r_dst;
        w_alu_next         = r_alu;
        w_wb_valid_next    = 1'b0;
        w_wb_regwrite_next = r_wb_regwrite;
        w_wb_data_next     = r_wb_data;
        w_wb_dst_next      = r_wb_dst;

        case (r_state)
            ST_IDLE: begin
                if (bus.valid_in) begin
                    if (bus.do_read || bus.do_write) begin
                        w_state_next     = ST_REQ;
                        w_mem_req_next   = 1'b1;
                        // read+write together is a write
                        w_mem_we_next    = bus.do_write;
                        w_mem_addr_next  = word_addr(bus.alu_result);
                        w_mem_wdata_next = w_wdata;
                        w_mem_be_next    = w_be;
                        w_lane_next      = bus.alu_result[1:0];
                        w_is_byte_next   = bus.is_byte;
                        w_memtoreg_next  = bus.memtoreg;
                        w_regwrite_next  = bus.regwrite_in;
                        w_dst_next       = bus.dst_reg_in;
                        w_alu_next       = bus.alu_result;
                    end else begin
                        w_wb_valid_next    = 1'b1;
                        w_wb_regwrite_next = bus.regwrite_in;
                        w_wb_data_next     = bus.alu_result;
                        w_wb_dst_next      = bus.dst_reg_in;
                    end
                end
            end
            ST_REQ: begin
                if (bus.mem_ack) begin
                    w_state_next    = ST_IDLE;
                    w_mem_req_next  = 1'b0;
                    w_wb_valid_next = 1'b1;
                    w_wb_dst_next   = r_dst;
                    if (r_mem_we) begin
                        w_wb_regwrite_next = 1'b0;
                        w_wb_data_next     = r_alu;
                    end else begin
                        w_wb_regwrite_next = r_regwrite;
                        w_wb_data_next     = r_memtoreg ? w_load_data : r_alu;
                    end
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= ST_IDLE;
            r_mem_req     <= 1'b0;
            r_mem_we      <= 1'b0;
            r_mem_addr    <= '0;
            r_mem_wdata   <= '0;
            r_mem_be      <= 4'b0000;
            r_lane        <= 2'b00;
            r_is_byte     <= 1'b0;
            r_memtoreg    <= 1'b0;
            r_regwrite    <= 1'b0;
            r_dst         <= '0;
            r_alu         <= '0;
            r_wb_valid    <= 1'b0;
            r_wb_regwrite <= 1'b0;
            r_wb_data     <= '0;
            r_wb_dst      <= '0;
        end else begin
            r_state       <= w_state_next;
            r_mem_req     <= w_mem_req_next;
            r_mem_we      <= w_mem_we_next;
            r_mem_addr    <= w_mem_addr_next;
            r_mem_wdata   <= w_mem_wdata_next;
            r_mem_be      <= w_mem_be_next;
            r_lane        <= w_lane_next;
            r_is_byte     <= w_is_byte_next;
            r_memtoreg    <= w_memtoreg_next;
            r_regwrite    <= w_regwrite_next;
            r_dst         <= w_dst_next;
            r_alu         <= w_alu_next;
            r_wb_valid    <= w_wb_valid_next;
            r_wb_regwrite <= w_wb_regwrite_next;
            r_wb_data     <= w_wb_data_next;
            r_wb_dst      <= w_wb_dst_next;
        end
    end

    assign bus.mem_req     = r_mem_req;
    assign bus.mem_we      = r_mem_we;
    assign bus.mem_addr    = r_mem_addr;
    assign bus.mem_wdata   = r_mem_wdata;
    assign bus.mem_be      = r_mem_be;
    assign bus.stall       = (r_state == ST_REQ);
    assign bus.wb_valid    = r_wb_valid;
    assign bus.wb_regwrite = r_wb_regwrite;
    assign bus.wb_data     = r_wb_data;
    assign bus.wb_dst_reg  = r_wb_dst;

endmodule

// File: tb/tb_mem_stage.sv
// ---------------------------------------------------------------------------
// tb_mem_stage
// Directed and randomized checks of mem_stage against a behavioural model of
// the byte-lane rules and handshake timing. Inputs change and outputs are
// sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_mem_stage;
    import mem_stage_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mem_stage_if bus_if ();

    mem_stage u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // ---- reference model (arithmetic form of the lane rules) ----
    function automatic logic [31:0] ref_be(input bit byt, input logic [31:0] a);
        return byt ? (32'd1 << (a % 4)) : 32'd15;
    endfunction

    function automatic logic [31:0] ref_wdata(input bit byt, input logic [31:0] d);
        return byt ? (d & 32'hFF) * 32'h0101_0101 : d;
    endfunction

    function automatic logic [31:0] ref_load(input bit byt, input logic [31:0] a, input logic [31:0] rd);
        logic [31:0] v;
        if (!byt) return rd;
        v = (rd >> (8 * (a % 4))) & 32'hFF;
        if (v >= 32'd128) v = v | 32'hFFFF_FF00;
        return v;
    endfunction

    task automatic idle_inputs();
        bus_if.valid_in    = 1'b0;
        bus_if.alu_result  = '0;
        bus_if.data_store  = '0;
        bus_if.do_read     = 1'b0;
        bus_if.do_write    = 1'b0;
        bus_if.is_byte     = 1'b0;
        bus_if.memtoreg    = 1'b0;
        bus_if.regwrite_in = 1'b0;
        bus_if.dst_reg_in  = '0;
        bus_if.mem_ack     = 1'b0;
        bus_if.mem_rdata   = '0;
    endtask

    // One full operation starting at a falling edge; k = cycles from
    // mem_req rising to the ack being sampled (k >= 1).
    task automatic run_op(input string tag, input bit rd, input bit wr, input bit byt,
                          input bit m2r, input bit rw, input logic [31:0] alu,
                          input logic [31:0] dsv, input logic [31:0] rdata,
                          input logic [4:0] dst, input int k);
        logic [31:0] exp_wb;
        bit          is_mem;
        is_mem = rd | wr;
        exp_wb = (is_mem && !wr && m2r) ? ref_load(byt, alu, rdata) : alu;

        bus_if.valid_in    = 1'b1;
        bus_if.do_read     = rd;
        bus_if.do_write    = wr;
        bus_if.is_byte     = byt;
        bus_if.memtoreg    = m2r;
        bus_if.regwrite_in = rw;
        bus_if.alu_result  = alu;
        bus_if.data_store  = dsv;
        bus_if.dst_reg_in  = dst;
        @(negedge clk);

        if (!is_mem) begin
            bus_if.valid_in = 1'b0;
            check({tag, ".wb_valid"},    32'(bus_if.wb_valid),    32'd1);
            check({tag, ".wb_data"},     bus_if.wb_data,          exp_wb);
            check({tag, ".wb_dst"},      32'(bus_if.wb_dst_reg),  32'(dst));
            check({tag, ".wb_regwrite"}, 32'(bus_if.wb_regwrite), 32'(rw));
            check({tag, ".stall"},       32'(bus_if.stall),       32'd0);
            check({tag, ".mem_req"},     32'(bus_if.mem_req),     32'd0);
        end else begin
            // junk on the execute side while stalled must be ignored
            bus_if.do_read    = 1'b0;
            bus_if.do_write   = 1'b0;
            bus_if.alu_result = $urandom;
            bus_if.data_store = $urandom;
            bus_if.is_byte    = 1'($urandom);
            bus_if.dst_reg_in = 5'($urandom);
            for (int c = 1; c <= k; c++) begin
                check({tag, ".stall"},    32'(bus_if.stall),    32'd1);
                check({tag, ".mem_req"},  32'(bus_if.mem_req),  32'd1);
                check({tag, ".mem_we"},   32'(bus_if.mem_we),   32'(wr));
                check({tag, ".mem_addr"}, bus_if.mem_addr,      alu & 32'hFFFF_FFFC);
                check({tag, ".wb_valid"}, 32'(bus_if.wb_valid), 32'd0);
                if (wr) begin
                    check({tag, ".mem_be"},    32'(bus_if.mem_be), ref_be(byt, alu));
                    check({tag, ".mem_wdata"}, bus_if.mem_wdata,   ref_wdata(byt, dsv));
                end
                if (c == k) begin
                    bus_if.mem_ack   = 1'b1;
                    bus_if.mem_rdata = rdata;
                end
                @(negedge clk);
            end
            bus_if.mem_ack   = 1'b0;
            bus_if.mem_rdata = $urandom;
            bus_if.valid_in  = 1'b0;
            check({tag, ".wb_valid"},    32'(bus_if.wb_valid),    32'd1);
            check({tag, ".stall"},       32'(bus_if.stall),       32'd0);
            check({tag, ".mem_req"},     32'(bus_if.mem_req),     32'd0);
            check({tag, ".wb_dst"},      32'(bus_if.wb_dst_reg),  32'(dst));
            check({tag, ".wb_regwrite"}, 32'(bus_if.wb_regwrite), wr ? 32'd0 : 32'(rw));
            if (!wr) check({tag, ".wb_data"}, bus_if.wb_data, exp_wb);
        end
        $display("[TB] %s rd=%0d wr=%0d byte=%0d m2r=%0d rw=%0d alu=%h st=%h rdata=%h dst=%0d k=%0d wb=%h",
                 tag, rd, wr, byt, m2r, rw, alu, dsv, rdata, dst, k, bus_if.wb_data);
        @(negedge clk);
        check({tag, ".pulse_end"}, 32'(bus_if.wb_valid),   32'd0);
        check({tag, ".dst_hold"},  32'(bus_if.wb_dst_reg), 32'(dst));
    endtask

    initial begin
        idle_inputs();
        reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst.mem_req",     32'(bus_if.mem_req),     32'd0);
        check("rst.mem_we",      32'(bus_if.mem_we),      32'd0);
        check("rst.mem_be",      32'(bus_if.mem_be),      32'd0);
        check("rst.stall",       32'(bus_if.stall),       32'd0);
        check("rst.wb_valid",    32'(bus_if.wb_valid),    32'd0);
        check("rst.wb_regwrite", 32'(bus_if.wb_regwrite), 32'd0);
        check("rst.mem_addr",    bus_if.mem_addr,         32'd0);
        check("rst.mem_wdata",   bus_if.mem_wdata,        32'd0);
        check("rst.wb_data",     bus_if.wb_data,          32'd0);
        check("rst.wb_dst",      32'(bus_if.wb_dst_reg),  32'd0);

        // release and accept on the very first rising edge
        reset = 1'b1;
        run_op("alu",    1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_1234, 32'h0, 32'h0, 5'd5, 1);
        run_op("wload",  1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 5'd3, 3);
        run_op("bload",  1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0203, 32'h0, 32'h80FF_FF7F, 5'd4, 2);
        check("bload.const", bus_if.wb_data, 32'hFFFF_FF80);
        run_op("bstore", 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0302, 32'h0000_00A5, 32'h0, 5'd6, 1);
        run_op("rdwr",   1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0407, 32'h1357_9BDF, 32'h5555_AAAA, 5'd8, 2);
        run_op("nom2r",  1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0511, 32'h0, 32'h1234_5678, 5'd9, 1);

        // ack while idle is ignored
        bus_if.mem_ack   = 1'b1;
        bus_if.mem_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        bus_if.mem_ack = 1'b0;
        check("idle_ack.wb_valid", 32'(bus_if.wb_valid), 32'd0);
        check("idle_ack.stall",    32'(bus_if.stall),    32'd0);
        check("idle_ack.mem_req",  32'(bus_if.mem_req),  32'd0);
        $display("[TB] idle_ack ignored");

        // reset during REQ, late ack afterwards
        bus_if.valid_in    = 1'b1;
        bus_if.do_read     = 1'b1;
        bus_if.memtoreg    = 1'b1;
        bus_if.regwrite_in = 1'b1;
        bus_if.alu_result  = 32'h0000_0600;
        bus_if.dst_reg_in  = 5'd10;
        @(negedge clk);
        bus_if.valid_in = 1'b0;
        bus_if.do_read  = 1'b0;
        check("rreq.mem_req", 32'(bus_if.mem_req), 32'd1);
        reset = 1'b0;
        #1;
        check("rreq.async_req",   32'(bus_if.mem_req),  32'd0);
        check("rreq.async_stall", 32'(bus_if.stall),    32'd0);
        check("rreq.async_addr",  bus_if.mem_addr,      32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        bus_if.mem_ack   = 1'b1;
        bus_if.mem_rdata = 32'h0BAD_F00D;
        @(negedge clk);
        bus_if.mem_ack = 1'b0;
        check("rreq.late_wbv",   32'(bus_if.wb_valid), 32'd0);
        check("rreq.late_stall", 32'(bus_if.stall),    32'd0);
        check("rreq.late_req",   32'(bus_if.mem_req),  32'd0);
        @(negedge clk);
        check("rreq.late_wbv2",  32'(bus_if.wb_valid), 32'd0);
        $display("[TB] reset during REQ dropped the load");

        // back-to-back: load then an ALU bundle held by stall
        bus_if.valid_in    = 1'b1;
        bus_if.do_read     = 1'b1;
        bus_if.do_write    = 1'b0;
        bus_if.is_byte     = 1'b0;
        bus_if.memtoreg    = 1'b1;
        bus_if.regwrite_in = 1'b1;
        bus_if.alu_result  = 32'h0000_0400;
        bus_if.dst_reg_in  = 5'd7;
        @(negedge clk);
        check("b2b.req", 32'(bus_if.mem_req), 32'd1);
        bus_if.do_read     = 1'b0;
        bus_if.alu_result  = 32'h0000_CAFE;
        bus_if.dst_reg_in  = 5'd9;
        check("b2b.stall1", 32'(bus_if.stall), 32'd1);
        @(negedge clk);
        check("b2b.stall2", 32'(bus_if.stall), 32'd1);
        bus_if.mem_ack   = 1'b1;
        bus_if.mem_rdata = 32'h1111_2222;
        @(negedge clk);
        bus_if.mem_ack = 1'b0;
        check("b2b.ld_wbv",  32'(bus_if.wb_valid),   32'd1);
        check("b2b.ld_data", bus_if.wb_data,         32'h1111_2222);
        check("b2b.ld_dst",  32'(bus_if.wb_dst_reg), 32'd7);
        @(negedge clk);
        bus_if.valid_in = 1'b0;
        check("b2b.alu_wbv",  32'(bus_if.wb_valid),   32'd1);
        check("b2b.alu_data", bus_if.wb_data,         32'h0000_CAFE);
        check("b2b.alu_dst",  32'(bus_if.wb_dst_reg), 32'd9);
        @(negedge clk);
        check("b2b.end", 32'(bus_if.wb_valid), 32'd0);
        $display("[TB] back-to-back load + alu");

        // randomized operations against the model
        for (int i = 0; i < 40; i++) begin
            run_op("rnd", 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                   1'($urandom), $urandom, $urandom, $urandom, 5'($urandom),
                   int'($urandom_range(1, 4)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
